// File: rtl/data_mem_responder_if.sv
// Core data-port bundle: byte address, store data, load/store strobes, load data.
// The core drives the master side; the memory responder sits on the slave side.
interface data_mem_responder_if;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_mem_write;
   logic        data_mem_read;
   logic [31:0] data_rdata;

   modport master (
      output data_addr,
      output data_wdata,
      output data_mem_write,
      output data_mem_read,
      input  data_rdata
   );

   modport slave (
      input  data_addr,
      input  data_wdata,
      input  data_mem_write,
      input  data_mem_read,
      output data_rdata
   );
endinterface

// File: rtl/data_mem_responder.sv
// Data-side RAM plus MMIO peripherals (GPIO, timer, cycle counter) for a single-cycle core.
// Reads are combinational and stores commit at the clock edge; the responder never stalls the core.
module data_mem_responder #(
   parameter int unsigned DEPTH     = 256,
   parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   data_mem_responder_if.slave  bus,
   output logic [31:0]          gpio_out,
   output logic                 timer_irq,
   output logic                 access_err
);

   localparam int unsigned AW = $clog2(DEPTH);

   localparam logic [15:0] OFF_GPIO  = 16'h0000;
   localparam logic [15:0] OFF_COUNT = 16'h0004;
   localparam logic [15:0] OFF_CMP   = 16'h0008;
   localparam logic [15:0] OFF_CTRL  = 16'h000C;
   localparam logic [15:0] OFF_CYCLE = 16'h0010;

   logic [31:0] ram_q [DEPTH];

   logic [31:0] gpio_q, gpio_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] cmp_q, cmp_d;
   logic [31:0] cyc_q, cyc_d;
   logic        en_q, en_d;
   logic        irq_q, irq_d;
   logic        err_q, err_d;

   logic          any_strobe;
   logic          mmio_hit;
   logic          ram_hit;
   logic          bad_access;
   logic          ram_we;
   logic          mmio_we;
   logic          match;
   logic [15:0]   off;
   logic [AW-1:0] ram_idx;
   logic [31:0]   rdata_mux;

   always_comb begin
      any_strobe = bus.data_mem_write | bus.data_mem_read;
      mmio_hit   = (bus.data_addr[31:16] == MMIO_BASE[31:16]);
      ram_hit    = !mmio_hit && ({2'b00, bus.data_addr[31:2]} < 32'(DEPTH));
      bad_access = any_strobe &&
                   ((bus.data_addr[1:0] != 2'b00) || !(mmio_hit || ram_hit));
      ram_we     = bus.data_mem_write && ram_hit && !bad_access;
      mmio_we    = bus.data_mem_write && mmio_hit && !bad_access;
      off        = bus.data_addr[15:0];
      ram_idx    = bus.data_addr[AW+1:2];
      match      = en_q && (cnt_q == cmp_q);
   end

   // Load path: anything faulting or not strobed returns zero.
   always_comb begin
      rdata_mux = 32'h0;
      if (bus.data_mem_read && !bad_access) begin
         if (ram_hit) begin
            rdata_mux = ram_q[ram_idx];
         end else begin
            case (off)
               OFF_GPIO:  rdata_mux = gpio_q;
               OFF_COUNT: rdata_mux = cnt_q;
               OFF_CMP:   rdata_mux = cmp_q;
               OFF_CTRL:  rdata_mux = {30'h0, irq_q, en_q};
               OFF_CYCLE: rdata_mux = cyc_q;
               default:   rdata_mux = 32'h0;
            endcase
         end
      end
   end

   assign bus.data_rdata = rdata_mux;

   always_comb begin
      gpio_d = gpio_q;
      cmp_d  = cmp_q;
      en_d   = en_q;
      irq_d  = irq_q;
      cyc_d  = cyc_q + 32'h1;
      err_d  = err_q | bad_access;
      if (!en_q) begin
         cnt_d = cnt_q;
      end else if (match) begin
         cnt_d = 32'h0;
      end else begin
         cnt_d = cnt_q + 32'h1;
      end

      if (mmio_we) begin
         case (off)
            OFF_GPIO:  gpio_d = bus.data_wdata;
            OFF_COUNT: cnt_d  = bus.data_wdata;
            OFF_CMP:   cmp_d  = bus.data_wdata;
            OFF_CTRL: begin
               en_d = bus.data_wdata[0];
               if (bus.data_wdata[1]) begin
                  irq_d = 1'b0;
               end
            end
            default: ;
         endcase
      end

      // A match on the same edge wins over write-1-to-clear.
      if (match) begin
         irq_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gpio_q <= 32'h0;
         cnt_q  <= 32'h0;
         cmp_q  <= 32'h0;
         cyc_q  <= 32'h0;
         en_q   <= 1'b0;
         irq_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         gpio_q <= gpio_d;
         cnt_q  <= cnt_d;
         cmp_q  <= cmp_d;
         cyc_q  <= cyc_d;
         en_q   <= en_d;
         irq_q  <= irq_d;
         err_q  <= err_d;
      end
   end

   // RAM has no reset; a store coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (rst_n && ram_we) begin
         ram_q[ram_idx] <= bus.data_wdata;
      end
   end

   assign gpio_out   = gpio_q;
   assign timer_irq  = irq_q;
   assign access_err = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: stimulus pushes expected responses from a behavioural model, a monitor pops and compares.
module tb_data_mem_responder;
   localparam int unsigned DEPTH = 256;
   localparam logic [31:0] MB    = 32'hFFFF_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] gpio_out;
   logic        timer_irq;
   logic        access_err;

   always #5 clk = ~clk;

   data_mem_responder_if bus ();

   data_mem_responder #(.DEPTH(DEPTH), .MMIO_BASE(MB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .gpio_out   (gpio_out),
      .timer_irq  (timer_irq),
      .access_err (access_err)
   );

   typedef struct {
      logic [31:0] rd;
      bit          chk_rd;
      logic [31:0] gpio;
      bit          irq;
      bit          err;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Behavioural model state
   logic [31:0] m_ram [DEPTH];
   bit          m_vld [DEPTH];
   logic [31:0] m_gpio, m_cnt, m_cmp, m_cyc;
   bit          m_en, m_irq, m_err;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic bit is_mmio(input logic [31:0] a);
      return (a >= MB) && (a - MB < 32'h1_0000);
   endfunction

   function automatic bit is_bad(input logic [31:0] a, input bit strobe);
      bit mapped;
      mapped = is_mmio(a) || (a < DEPTH * 4);
      return strobe && ((a % 4 != 0) || !mapped);
   endfunction

   function automatic void m_reset();
      m_gpio = 0; m_cnt = 0; m_cmp = 0; m_cyc = 0;
      m_en = 0; m_irq = 0; m_err = 0;
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
   endfunction

   function automatic void m_expect(input logic [31:0] a, input bit re,
                                    output logic [31:0] v, output bit known);
      v = 0;
      known = 1;
      if (re && !is_bad(a, 1'b1)) begin
         if (is_mmio(a)) begin
            case (a - MB)
               32'h0:   v = m_gpio;
               32'h4:   v = m_cnt;
               32'h8:   v = m_cmp;
               32'hC:   v = {30'h0, m_irq, m_en};
               32'h10:  v = m_cyc;
               default: v = 0;
            endcase
         end else begin
            v = m_ram[a / 4];
            known = m_vld[a / 4];
         end
      end
   endfunction

   function automatic void m_step(input logic [31:0] a, input logic [31:0] wd, input bit we, input bit re);
      bit          bad, match, nirq;
      logic [31:0] ncnt;
      bad   = is_bad(a, we || re);
      match = m_en && (m_cnt == m_cmp);
      ncnt  = m_en ? (match ? 32'h0 : m_cnt + 1) : m_cnt;
      nirq  = m_irq;
      if (we && !bad) begin
         if (is_mmio(a)) begin
            case (a - MB)
               32'h0: m_gpio = wd;
               32'h4: ncnt = wd;
               32'h8: m_cmp = wd;
               32'hC: begin
                  m_en = wd[0];
                  if (wd[1]) nirq = 0;
               end
               default: ;
            endcase
         end else begin
            m_ram[a / 4] = wd;
            m_vld[a / 4] = 1;
         end
      end
      if (match) nirq = 1;
      m_cnt = ncnt;
      m_irq = nirq;
      m_cyc = m_cyc + 1;
      m_err = m_err | bad;
   endfunction

   task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input bit we, input bit re);
      exp_t e;
      bus.data_addr      = a;
      bus.data_wdata     = wd;
      bus.data_mem_write = we;
      bus.data_mem_read  = re;
      m_expect(a, re, e.rd, e.chk_rd);
      e.gpio = m_gpio;
      e.irq  = m_irq;
      e.err  = m_err;
      sb_q.push_back(e);
      @(posedge clk);
      m_step(a, wd, we, re);
      #1;
   endtask

   // Asynchronous reset asserted between edges, with a store pending on the bus.
   task automatic do_reset();
      bus.data_addr      = MB;
      bus.data_wdata     = 32'h1234_5678;
      bus.data_mem_write = 1'b1;
      bus.data_mem_read  = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_gpio", gpio_out, 32'h0);
      check("async_rst_irq", {31'h0, timer_irq}, 32'h0);
      check("async_rst_err", {31'h0, access_err}, 32'h0);
      m_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Monitor: compare every cycle the stimulus has queued an expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (bus.data_mem_read && e.chk_rd) check("rdata", bus.data_rdata, e.rd);
            if (!bus.data_mem_read) check("rdata_idle", bus.data_rdata, 32'h0);
            check("gpio_out", gpio_out, e.gpio);
            check("timer_irq", {31'h0, timer_irq}, {31'h0, e.irq});
            check("access_err", {31'h0, access_err}, {31'h0, e.err});
         end
      end
   end

   initial begin
      logic [31:0] a, wd;
      int          kind;
      bus.data_addr      = 0;
      bus.data_wdata     = 0;
      bus.data_mem_write = 0;
      bus.data_mem_read  = 0;
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      cyc(MB + 32'h4, 0, 0, 1);
      cyc(MB + 32'hC, 0, 0, 1);

      // RAM store/load, idle read returns zero
      cyc(32'h10, 32'hDEAD_BEEF, 1, 0);
      cyc(32'h10, 0, 0, 1);
      cyc(32'h14, 0, 0, 0);
      cyc(32'h14, 32'h0BAD_F00D, 1, 1);
      cyc(32'h14, 0, 0, 1);

      // GPIO then async reset
      cyc(MB, 32'h0000_00A5, 1, 0);
      cyc(MB, 0, 0, 1);
      check("gpio_a5", gpio_out, 32'h0000_00A5);
      do_reset();
      cyc(MB, 0, 0, 1);

      // Timer: cmp=3, count=0, enable
      cyc(MB + 32'h8, 3, 1, 0);
      cyc(MB + 32'h4, 0, 1, 0);
      cyc(MB + 32'hC, 1, 1, 0);
      for (int i = 0; i < 5; i++) cyc(MB + 32'h4, 0, 0, 1);
      check("irq_after_match", {31'h0, timer_irq}, 32'h1);
      while (m_cnt == m_cmp) cyc(MB + 32'hC, 0, 0, 1);
      cyc(MB + 32'hC, 3, 1, 0);
      check("irq_w1c", {31'h0, timer_irq}, 32'h0);
      for (int i = 0; i < 8 && m_cnt != m_cmp; i++) cyc(MB + 32'h4, 0, 0, 1);
      cyc(MB + 32'hC, 3, 1, 1);
      check("match_beats_w1c", {31'h0, timer_irq}, 32'h1);
      cyc(MB + 32'h4, 32'h100, 1, 0);
      cyc(MB + 32'h4, 0, 0, 1);
      cyc(MB + 32'hC, 2, 1, 0);
      cyc(MB + 32'h4, 0, 0, 1);

      // Misaligned store must not hit RAM word 0; unmapped load returns 0
      cyc(32'h0, 32'h5555_AAAA, 1, 0);
      cyc(32'h402, 32'hFFFF_FFFF, 1, 0);
      cyc(32'h0, 0, 0, 1);
      cyc(32'h0001_0000, 0, 0, 1);
      for (int i = 0; i < 3; i++) cyc(32'h0, 0, 0, 1);

      // Cycle counter: reads 5 apart, writes ignored
      cyc(MB + 32'h10, 0, 0, 1);
      for (int i = 0; i < 4; i++) cyc(MB + 32'h10, 0, 0, 0);
      cyc(MB + 32'h10, 0, 0, 1);
      cyc(MB + 32'h10, 32'h0, 1, 0);
      cyc(MB + 32'h10, 0, 0, 1);
      cyc(MB + 32'h14, 32'h77, 1, 1);
      cyc(MB + 32'h14, 0, 0, 1);

      // Randomized traffic with a reset in the middle
      do_reset();
      for (int n = 0; n < 800; n++) begin
         if (n == 400) do_reset();
         kind = $urandom_range(0, 99);
         wd   = $urandom;
         if (kind < 45) begin
            a = {22'h0, 8'($urandom_range(0, 31)), 2'b00};
         end else if (kind < 85) begin
            case ($urandom_range(0, 6))
               0: a = MB;
               1: begin a = MB + 32'h4; wd = $urandom_range(0, 12); end
               2: begin a = MB + 32'h8; wd = $urandom_range(0, 6); end
               3: begin a = MB + 32'hC; wd = $urandom_range(0, 3); end
               4: a = MB + 32'h10;
               5: a = MB + 32'h14;
               default: a = MB + 32'h100;
            endcase
         end else if (kind < 97) begin
            a = MB + 32'hC;
            wd = $urandom_range(1, 3);
         end else if (kind < 99) begin
            a = {22'h0, 8'($urandom_range(0, 31)), 2'($urandom_range(1, 3))};
         end else begin
            a = 32'h0001_0000 + {24'h0, 8'($urandom_range(0, 63))} * 4;
         end
         cyc(a, wd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      bus.data_mem_write = 0;
      bus.data_mem_read  = 0;
      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
      if (sb_q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-side responder for the single-cycle MIPS core: it answers the core's data-memory requests (address, write data, read/write strobes) from a word-addressed RAM and a small memory-mapped peripheral region (GPIO output register, programmable timer with interrupt flag, free-running cycle counter). It sits in the MCU top level beside the instruction memory, driven directly by the core's data port. Reads return the same cycle; writes commit on the clock edge.

## Interface
- DEPTH, 256, RAM size in 32-bit words (power of two, ≥ 4)
- MMIO_BASE, 32'hFFFF_0000, base byte address of the peripheral region (64 KiB window)

- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- data_addr  input  32  byte address from core (ALU result)
- data_wdata  input  32  store data from core (rt value)
- data_mem_write  input  1  store strobe, one word per asserted cycle
- data_mem_read  input  1  load strobe
- data_rdata  output  32  load data, combinational
- gpio_out  output  32  GPIO output register
- timer_irq  output  1  sticky timer match flag
- access_err  output  1  sticky error flag (misaligned or unmapped access)

## Operation
- Decode: MMIO hit when data_addr[31:16] == MMIO_BASE[31:16]; RAM hit when not MMIO and data_addr[31:2] < DEPTH; otherwise unmapped. Misaligned when data_addr[1:0] != 0 and a strobe is asserted.
- RAM: index = data_addr[log2(DEPTH)+1:2]. Contents not reset (X after power-up).
- MMIO map (offset from MMIO_BASE):
  - 0x00 GPIO_OUT RW.
  - 0x04 TIMER_COUNT RW; write loads count.
  - 0x08 TIMER_CMP RW.
  - 0x0C TIMER_CTRL: bit0 enable RW; bit1 irq status, read 1 when set, write 1 clears; other bits read 0.
  - 0x10 CYCLE_CNT RO, writes ignored.
  - Other offsets: read 0, writes ignored, not an error.
- Timer: when enable=1, each cycle: if count == cmp, count ← 0 and irq ← 1; else count ← count+1. When enable=0, count holds.
- CYCLE_CNT increments every cycle after reset, wraps 0xFFFF_FFFF → 0.
- Errors: misaligned or unmapped access with either strobe asserted → write suppressed, read returns 0, access_err ← 1 (sticky; cleared only by reset).
- data_rdata = 0 whenever data_mem_read = 0.
- Both strobes asserted: read returns pre-write value; write commits at edge.

## Timing
- Reads: zero-latency combinational from data_addr/data_mem_read to data_rdata (required by single-cycle core); MMIO reads return current register value.
- Writes: take effect at the rising edge where data_mem_write = 1; visible to reads in the next cycle.
- Priority at one edge:
  - TIMER_COUNT write overrides increment and match wrap.
  - Match-set of irq overrides a same-cycle write-1-to-clear.
  - A TIMER_CTRL write updates enable at the edge; the new enable governs counting from the next cycle.
- Reset (rst_n low, asynchronous, any cycle, including mid-store):
  - gpio_out=0, timer count=0, cmp=0, enable=0, timer_irq=0, CYCLE_CNT=0, access_err=0.
  - In-flight write discarded.
  - RAM contents undefined.
- timer_irq is a register output; it rises the cycle after the match edge evaluation.

## Test plan
- Store 0xDEADBEEF to 0x0000_0010, load same address next cycle → data_rdata=0xDEADBEEF; load 0x0000_0014 with read=0 → data_rdata=0.
- Store 0x0000_00A5 to MMIO_BASE+0x00 → gpio_out=0x0000_00A5 after the edge; reset mid-run → gpio_out=0 immediately, asynchronous to clk.
- cmp=3, count=0, enable=1 → count 1,2,3 then 0, timer_irq=1 four cycles after enable takes effect; write 0x2 to CTRL on a non-match cycle → irq=0, enable stays 0x... (write 0x3 to keep enable=1).
- W1C of irq on the same edge as a match → timer_irq remains 1; TIMER_COUNT write of 0x100 on the same edge as a would-be increment → count reads 0x100.
- Store to 0x0000_0402 (misaligned) → RAM unchanged, access_err=1; load from 0x0001_0000 with DEPTH=256 → data_rdata=0, access_err stays 1 until rst_n low.
- Read CYCLE_CNT twice 5 cycles apart → difference 5; write to CYCLE_CNT → value unaffected.
